// File: rtl/capture_pkg.sv
// capture_pkg: state encodings and lane-order constant shared by the capture buffer files
package capture_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_ARMED    = 2'd1;
  localparam logic [STATE_W-1:0] ST_POSTTRIG = 2'd2;
  localparam logic [STATE_W-1:0] ST_READOUT  = 2'd3;
  localparam bit LANE0_FIRST = 1'b1;
endpackage

// File: rtl/trigger_capture_buffer_if.sv
// trigger_capture_buffer_if: sample input, trigger control and byte readout signals of the capture buffer
interface trigger_capture_buffer_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 1024
);
  import capture_pkg::*;
  localparam int ADDR_W = $clog2(DEPTH);
  logic [LANES*LANE_W-1:0] DataIn;
  logic                    DataInValid;
  logic                    Arm;
  logic                    FastTrigger;
  logic [ADDR_W:0]         PostTrigCount;
  logic                    ReadEnable;
  logic [LANE_W-1:0]       DataOut;
  logic                    DataValid;
  logic                    DataReadyToSend;
  logic [STATE_W-1:0]      State;
  modport master (
    output DataIn, DataInValid, Arm, FastTrigger, PostTrigCount, ReadEnable,
    input  DataOut, DataValid, DataReadyToSend, State
  );
  modport slave (
    input  DataIn, DataInValid, Arm, FastTrigger, PostTrigCount, ReadEnable,
    output DataOut, DataValid, DataReadyToSend, State
  );
endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, synchronous write, one-cycle registered read
module capture_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/trigger_capture_buffer.sv
// trigger_capture_buffer: circular pre-trigger capture, post-trigger fill, oldest-first byte readout
// Define AUTO_REARM_EN to re-enter ARMED after each readout instead of waiting for Arm.
module trigger_capture_buffer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic Clock,
  input logic Reset,
  trigger_capture_buffer_if.slave bus
);
  import capture_pkg::*;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW = ADDR_W + LW;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [STATE_W-1:0] st_q, st_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W:0] fill_q, fill_d, post_q, post_d, ptc_clamped;
  logic [LW-1:0] lane_q, lane_d, lane_sel_q, lane_sel_d, out_lane;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic dv_q, dv_d, we, issue, done;
  logic [LANES*LANE_W-1:0] rdata;
  capture_ram #(.DEPTH(DEPTH), .W(LANES*LANE_W)) u_ram (
    .clk(Clock), .we(we), .waddr(wr_ptr_q), .wdata(bus.DataIn),
    .re(issue), .raddr(rd_addr_q), .rdata(rdata)
  );
  always_comb begin
    ptc_clamped = bus.PostTrigCount > FULL ? FULL : bus.PostTrigCount;
    we = bus.DataInValid && (st_q == ST_ARMED || st_q == ST_POSTTRIG);
    issue = bus.ReadEnable && st_q == ST_READOUT && fill_q != '0;
    // Index of the final byte; fits CW bits even when fill is DEPTH.
    last = CW'(fill_q * LANES - 1);
    done = st_q == ST_READOUT && (fill_q == '0 || (issue && cnt_q == last));
    st_d = st_q;
    wr_ptr_d = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d = we && fill_q != FULL ? fill_q + 1'b1 : fill_q;
    post_d = post_q;
    rd_addr_d = rd_addr_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    lane_sel_d = issue ? lane_q : lane_sel_q;
    dv_d = issue;
    case (st_q)
      ST_IDLE: if (bus.Arm) begin
        st_d = ST_ARMED;
        fill_d = '0;
        post_d = ptc_clamped;
      end
      ST_ARMED: if (bus.FastTrigger) st_d = post_q == '0 ? ST_READOUT : ST_POSTTRIG;
      ST_POSTTRIG: if (we) begin
        post_d = post_q - 1'b1;
        if (post_q == (ADDR_W+1)'(1)) st_d = ST_READOUT;
      end
      default: begin
        if (issue) begin
          cnt_d = cnt_q + 1'b1;
          lane_d = lane_q == LW'(LANES-1) ? '0 : lane_q + 1'b1;
          rd_addr_d = lane_q == LW'(LANES-1) ? rd_addr_q + 1'b1 : rd_addr_q;
        end
        if (done) begin
`ifdef AUTO_REARM_EN
          st_d = ST_ARMED;
          fill_d = '0;
          post_d = ptc_clamped;
`else
          st_d = ST_IDLE;
`endif
        end
      end
    endcase
    // Readout starts at the oldest stored word.
    if (st_q != ST_READOUT && st_d == ST_READOUT) begin
      rd_addr_d = wr_ptr_d - fill_d[ADDR_W-1:0];
      lane_d = '0;
      cnt_d = '0;
    end
    out_lane = LANE0_FIRST ? lane_sel_q : LW'(LANES-1) - lane_sel_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st_q <= ST_IDLE;
      wr_ptr_q <= '0;
      fill_q <= '0;
      post_q <= '0;
      rd_addr_q <= '0;
      lane_q <= '0;
      lane_sel_q <= '0;
      cnt_q <= '0;
      dv_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q <= fill_d;
      post_q <= post_d;
      rd_addr_q <= rd_addr_d;
      lane_q <= lane_d;
      lane_sel_q <= lane_sel_d;
      cnt_q <= cnt_d;
      dv_q <= dv_d;
    end
  end
  assign bus.DataOut = dv_q ? rdata[out_lane*LANE_W +: LANE_W] : '0;
  assign bus.DataValid = dv_q;
  assign bus.DataReadyToSend = st_q == ST_READOUT;
  assign bus.State = st_q;
endmodule
